// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl: interrupt source controller.
// Captures rising edges on eight source lines into a pending register, masks
// them into a registered status vector and sequences a single irq line so that
// status is stable before irq rises and irq honours a minimum low gap.
// Optional build macro: IRQ_SRC_COALESCE_EN adds a WAIT state that delays
// irq assertion by COALESCE_CYCLES so that closely spaced events share a pulse.
module irq_source_ctrl #(
  parameter int unsigned GAP_CYCLES      = 2,
  parameter int unsigned COALESCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] src,
  input  logic       cfg_we,
  input  logic       cfg_re,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] cfg_rdata,
  output logic       irq,
  output logic [7:0] status
);

  // Both counters share one 4-bit register, so loads must fit 1..15.
  if (GAP_CYCLES < 1 || GAP_CYCLES > 15 ||
      COALESCE_CYCLES < 1 || COALESCE_CYCLES > 15) begin : g_bad_param
    $error("irq_source_ctrl: GAP_CYCLES and COALESCE_CYCLES must be 1..15");
  end

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);
`ifdef IRQ_SRC_COALESCE_EN
  localparam logic [3:0] COAL_LOAD = 4'(COALESCE_CYCLES);
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  // Config address map
  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_CLR  = 2'd2;
  localparam logic [1:0] A_SET  = 2'd3;

  logic [7:0] src_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] status_q, status_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] evt;
  logic [7:0] clr_bits;
  logic [7:0] set_bits;

  state_t     state_q;
  logic       irq_q;
  logic [3:0] cnt_q;

  // Edge detect, config decode and next pending/mask/status/readback values
  always_comb begin
    evt      = src & ~src_q;
    clr_bits = '0;
    set_bits = '0;
    mask_d   = mask_q;
    if (cfg_we) begin
      case (cfg_addr)
        A_MASK:  mask_d   = cfg_wdata;
        A_CLR:   clr_bits = cfg_wdata;
        A_SET:   set_bits = cfg_wdata;
        default: ;
      endcase
    end
    // Clear is applied first so a same-cycle event or set on the bit wins.
    pend_d   = (pend_q & ~clr_bits) | evt | set_bits;
    status_d = pend_d & mask_d;

    // Readback samples pre-write register values.
    rdata_d = rdata_q;
    if (cfg_re) begin
      case (cfg_addr)
        A_PEND:  rdata_d = pend_q;
        A_MASK:  rdata_d = mask_q;
        A_CLR:   rdata_d = '0;
        default: rdata_d = status_q;
      endcase
    end
  end

  // Source history, pending, mask, status and readback registers
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q    <= '1;
      pend_q   <= '0;
      mask_q   <= '0;
      status_q <= '0;
      rdata_q  <= '0;
    end else begin
      src_q    <= src;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
    end
  end

  // irq sequencer: decisions are made on registered status so irq always
  // trails a nonzero status by at least one full cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          irq_q <= 1'b0;
          if (status_q != '0) begin
`ifdef IRQ_SRC_COALESCE_EN
            state_q <= ST_WAIT;
            cnt_q   <= COAL_LOAD;
`else
            state_q <= ST_ASSERT;
            irq_q   <= 1'b1;
`endif
          end
        end
`ifdef IRQ_SRC_COALESCE_EN
        ST_WAIT: begin
          irq_q <= 1'b0;
          if (status_q == '0) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q <= 4'd1) begin
            state_q <= ST_ASSERT;
            irq_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`endif
        ST_ASSERT: begin
          if (status_q == '0) begin
            state_q <= ST_GAP;
            irq_q   <= 1'b0;
            cnt_q   <= GAP_LOAD;
          end else begin
            irq_q <= 1'b1;
          end
        end
        ST_GAP: begin
          irq_q <= 1'b0;
          // The last gap cycle hands over to IDLE, which re-evaluates status.
          if (cnt_q <= 4'd1) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          irq_q   <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign status    = status_q;
  assign irq       = irq_q;
  assign cfg_rdata = rdata_q;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Bench for irq_source_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_irq_source_ctrl;

  localparam int unsigned GAP  = 2;
  localparam int unsigned COAL = 4;
`ifdef IRQ_SRC_COALESCE_EN
  localparam int LAT = COAL;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] src = '0;
  logic       cfg_we = 1'b0;
  logic       cfg_re = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic [7:0] cfg_rdata;
  logic       irq;
  logic [7:0] status;

  always #5 clk = ~clk;

  irq_source_ctrl #(
    .GAP_CYCLES     (GAP),
    .COALESCE_CYCLES(COAL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src      (src),
    .cfg_we   (cfg_we),
    .cfg_re   (cfg_re),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .irq      (irq),
    .status   (status)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: register contents plus timing bookkeeping.
  // m_fall = first cycle irq was low after its last fall.
  // m_run  = consecutive cycles (ending now) with nonzero status while irq is
  //          low and the minimum gap has elapsed; irq rises once it exceeds LAT.
  logic [7:0] m_src_prev = 8'hFF;
  logic [7:0] m_pend = '0, m_mask = '0, m_status = '0, m_rdata = '0;
  logic       m_irq = 1'b0;
  int         m_cyc = 0;
  int         m_fall = -1000;
  int         m_run = 0;

  task automatic model_step();
    logic [7:0] evt, clr_b, set_b, pn, mn, sn;
    logic       irq_n;
    if (rst) begin
      m_src_prev = 8'hFF;
      m_pend = '0; m_mask = '0; m_status = '0; m_rdata = '0;
      m_irq = 1'b0; m_fall = -1000; m_run = 0;
    end else begin
      evt   = src & ~m_src_prev;
      clr_b = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : 8'h00;
      set_b = (cfg_we && cfg_addr == 2'd3) ? cfg_wdata : 8'h00;
      pn    = (m_pend & ~clr_b) | evt | set_b;
      mn    = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : m_mask;
      sn    = pn & mn;
      if (cfg_re) begin
        if (cfg_addr == 2'd0)      m_rdata = m_pend;
        else if (cfg_addr == 2'd1) m_rdata = m_mask;
        else if (cfg_addr == 2'd2) m_rdata = 8'h00;
        else                       m_rdata = m_status;
      end
      irq_n = m_irq ? (m_status != 0) : (m_run >= LAT + 1);
      if (m_irq && !irq_n) m_fall = m_cyc + 1;
      m_run = (sn != 0 && !irq_n && (m_cyc + 1) >= m_fall + int'(GAP)) ? m_run + 1 : 0;
      m_irq = irq_n;
      m_src_prev = src;
      m_pend = pn; m_mask = mn; m_status = sn;
    end
    m_cyc++;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  // Apply one cycle of inputs, advance model, then compare after the edge.
  task automatic cyc(input logic r, input logic [7:0] s, input logic we,
                     input logic re, input logic [1:0] a, input logic [7:0] wd);
    rst = r; src = s; cfg_we = we; cfg_re = re; cfg_addr = a; cfg_wdata = wd;
    model_step();
    @(posedge clk);
    #1;
    chk("status", status, m_status);
    chk("irq", {7'b0, irq}, {7'b0, m_irq});
    chk("cfg_rdata", cfg_rdata, m_rdata);
  endtask

  task automatic idle(input int n, input logic [7:0] s);
    for (int i = 0; i < n; i++) cyc(1'b0, s, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  logic [7:0] cur_src;
  logic [7:0] flip;
  logic       r_r, r_we, r_re;
  logic [1:0] r_a;
  logic [7:0] r_wd;

  initial begin
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("reset_status", status, 8'h00);
    chk("reset_irq", {7'b0, irq}, 8'h00);
    chk("reset_rdata", cfg_rdata, 8'h00);

    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 8'hFF);
    idle(3, 8'h00);
`ifndef IRQ_SRC_COALESCE_EN
    // Single event: status next cycle, irq the cycle after, clear and gap
    cyc(1'b0, 8'h08, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("t1_status", status, 8'h08);
    chk("t1_irq_early", {7'b0, irq}, 8'h00);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("t1_irq_rise", {7'b0, irq}, 8'h01);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'd2, 8'h08);
    chk("t1_status_clr", status, 8'h00);
    chk("t1_irq_hold", {7'b0, irq}, 8'h01);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("t1_irq_fall", {7'b0, irq}, 8'h00);
    idle(4, 8'h00);

    // Masked event, then unmask
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 8'h0F);
    cyc(1'b0, 8'h20, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("t2_masked_status", status, 8'h00);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 8'h00);
    chk("t2_pending", cfg_rdata, 8'h20);
    chk("t2_irq_masked", {7'b0, irq}, 8'h00);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 8'hFF);
    chk("t2_unmask_status", status, 8'h20);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("t2_irq", {7'b0, irq}, 8'h01);

    // New event while asserted: no re-pulse
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'd2, 8'hFF);
    idle(4, 8'h00);
    cyc(1'b0, 8'h01, 1'b0, 1'b0, 2'd0, 8'h00);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("t3_irq", {7'b0, irq}, 8'h01);
    cyc(1'b0, 8'h80, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("t3_status81", status, 8'h81);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'd2, 8'h01);
    chk("t3_status80", status, 8'h80);
    chk("t3_irq_hold", {7'b0, irq}, 8'h01);

    // Clear and event on the same bit in one cycle
    cyc(1'b0, 8'h04, 1'b1, 1'b0, 2'd2, 8'h04);
    chk("t4_status", status, 8'h84);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 8'h00);
    chk("t4_pending", cfg_rdata, 8'h84);
    chk("t4_irq", {7'b0, irq}, 8'h01);
`else
    // Two close events share one delayed pulse
    cyc(1'b0, 8'h01, 1'b0, 1'b0, 2'd0, 8'h00);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    cyc(1'b0, 8'h02, 1'b0, 1'b0, 2'd0, 8'h00);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("c_irq_early", {7'b0, irq}, 8'h00);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("c_irq_rise", {7'b0, irq}, 8'h01);
    chk("c_status", status, 8'h03);
`endif

    // Reset while irq is high, sources held high through release
    cyc(1'b1, 8'hFF, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("t5_irq_rst", {7'b0, irq}, 8'h00);
    chk("t5_status_rst", status, 8'h00);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0, 2'd0, 8'h00);
    cyc(1'b0, 8'hFF, 1'b0, 1'b1, 2'd0, 8'h00);
    cyc(1'b0, 8'hFF, 1'b1, 1'b1, 2'd1, 8'hFF);
    chk("t5_pending", cfg_rdata, 8'h00);
    cyc(1'b0, 8'hFF, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("t5_status", status, 8'h00);
    chk("t5_irq", {7'b0, irq}, 8'h00);

    // Randomized traffic
    cur_src = 8'hFF;
    for (int i = 0; i < 4000; i++) begin
      r_r  = ($urandom_range(0, 299) == 0);
      flip = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cur_src = cur_src ^ flip;
      r_we = ($urandom_range(0, 3) == 0);
      r_re = 1'($urandom);
      r_a  = 2'($urandom);
      r_wd = 8'($urandom);
      cyc(r_r, cur_src, r_we, r_re, r_a, r_wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_source_ctrl.md
Name: irq_source_ctrl

Overview:
- Interrupt source controller; the DUT-side driver of the irq/status pair that the testbench interrupt interface monitors.
- Captures rising edges on 8 source lines into a pending register and applies a mask, then drives registered status[7:0] and a single irq line.
- Software-style config port sets the mask and clears or forces pending bits (W1C / W1S).
- irq sequencing guarantees status is stable before irq rises and a minimum low gap between irq pulses.

Parameters:
GAP_CYCLES, 2, minimum irq low time (cycles) after deassert before re-assert; legal 1..15
COALESCE_CYCLES, 4, assert delay when IRQ_SRC_COALESCE_EN is defined; legal 1..15

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
src  input  8  interrupt sources, synchronous to clk; rising edge = event
cfg_we  input  1  config write strobe
cfg_re  input  1  config read strobe
cfg_addr  input  2  0=pending(RO) 1=mask(RW) 2=clear(W1C) 3=set(W1S)/status(RO)
cfg_wdata  input  8  write data
cfg_rdata  output  8  read data, valid 1 cycle after cfg_re
irq  output  1  interrupt request
status  output  8  registered pending & mask

Behaviour:
- One clock, clk. Reset is synchronous, active-high: rst.
- Reset values: pending=0, mask=0, status=0, irq=0, cfg_rdata=0, state=IDLE, src_d=8'hFF. A source already high at reset exit does not fire.
- Edge detect: evt = src & ~src_d; src_d <= src every cycle.
- Pending update per bit, next = (pend & ~clr) | evt | set.
  - clr = cfg_wdata when cfg_we && addr==2; set = cfg_wdata when cfg_we && addr==3.
  - A set or event in the same cycle as a clear on the same bit wins; the bit stays 1.
  - Writes to addr 0 are ignored.
- Mask: written via addr 1. status <= next_pending & next_mask, updated every cycle, including while irq is high.
- Latency: src edge in cycle N -> pending/status bit visible at N+1 -> irq=1 at N+2. status is always nonzero for at least one full cycle before irq rises.
- cfg_rdata registered: addr0 pending, 1 mask, 2 reads 0, 3 status. Read and write in the same cycle returns the pre-write value. Without cfg_re, cfg_rdata holds its previous value.
- FSM (irq registered from state):
  - IDLE: irq=0. If status!=0, go to ASSERT.
  - ASSERT: irq=1. If status==0 (all cleared or masked), irq=0 next cycle, load gap counter with GAP_CYCLES, go to GAP.
  - GAP: irq=0, decrement counter. At 0, go to IDLE. New events during GAP are latched in pending but do not raise irq until IDLE re-evaluates.
- New events arriving while in ASSERT: irq stays 1, status updates to include them; no re-pulse.
- Unmasking an already pending bit raises status next cycle and irq one cycle after that.
- rst mid-operation: all state returns to reset values on the next edge; irq drops with no gap enforced.

Optional Feature:
IRQ_SRC_COALESCE_EN
- Defined: adds a WAIT state between IDLE and ASSERT.
  - IDLE with status!=0 goes to WAIT and loads the counter with COALESCE_CYCLES.
  - In WAIT, irq=0. At count 0 with status!=0, go to ASSERT. If status==0 at any point, return to IDLE.
  - Edge-to-irq latency becomes 2+COALESCE_CYCLES.
- Undefined: no WAIT state; the latency above applies.

Test Plan:
- Reset, mask=8'hFF, pulse src[3] at cycle 10 -> status=8'h08 at 11, irq=1 at 12; write clear 8'h08 -> status=0 next cycle, irq=0 the cycle after, irq stays 0 for 2 cycles.
- mask=8'h0F, edge on src[5] -> pending=8'h20, status=0, irq stays 0; write mask 8'hFF -> status=8'h20, irq=1 one cycle later.
- irq high with status=8'h01, edge on src[7] -> status=8'h81, irq stays 1 continuously; clear 8'h01 -> status=8'h80, irq stays 1.
- Clear 8'h04 in the same cycle as a src[2] edge -> pending[2]=1, irq stays or becomes 1.
- src held 8'hFF through reset release -> no pending bits set. Assert rst while irq=1 -> irq=0, status=0, pending=0 on the next edge.
- With IRQ_SRC_COALESCE_EN: edges on src[0] at cycle 10 and src[1] at cycle 12 -> a single irq rise at cycle 16 with status=8'h03.
